// File: rtl/onchip_memory_pipelined.sv
// rtl/onchip_memory_pipelined.sv - Avalon-MM on-chip RAM with pipelined reads and a hardware clear engine
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset; release is synchronised internally
//   address       word address
//   byteenable    write byte lanes
//   chipselect    slave select
//   read, write   command strobes (write wins when both are high)
//   writedata     write data
//   clken         clock enable; low stalls the block
//   reset_req     stall request, same effect as clken low
//   clear_req     single-cycle pulse that starts a clear while running
//   readdata      read data, holds between valids
//   readdatavalid one pulse per accepted read, READ_LATENCY cycles later
//   waitrequest   command not accepted this cycle
//   init_done     high while in RUN
module onchip_memory_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 35000,
    parameter int ADDR_WIDTH     = 16,
    parameter int READ_LATENCY   = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic                    clken,
    input  logic                    reset_req,
    input  logic                    clear_req,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic                    init_done
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t state, next_state;
    logic [ADDR_WIDTH-1:0] clr_cnt, next_clr_cnt;

    logic [1:0] rst_sync;
    logic       rst_n_int;

    logic stall;
    logic in_range;
    logic cmd_acc;
    logic wr_acc;
    logic rd_acc;

    logic                  mem_we;
    logic [IDX_WIDTH-1:0]  mem_waddr;
    logic [NUM_LANES-1:0]  mem_wbe;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  stg_valid;
    logic [DATA_WIDTH-1:0] stg_data;

    // Assertion takes effect immediately; release is aligned to clk so
    // that every flop leaves reset on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n_int = rst_sync[1];

    assign stall       = !clken || reset_req;
    assign in_range    = 32'(address) < DEPTH;
    assign waitrequest = !rst_n_int || stall || (state != ST_RUN);
    assign init_done   = rst_n_int && (state == ST_RUN);
    assign cmd_acc     = chipselect && !waitrequest && (read || write);
    assign wr_acc      = cmd_acc && write;
    assign rd_acc      = cmd_acc && read && !write;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
        end else begin
            state   <= next_state;
            clr_cnt <= next_clr_cnt;
        end
    end

    always_comb begin
        next_state   = state;
        next_clr_cnt = clr_cnt;
        if (!stall) begin
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        next_clr_cnt = '0;
                        next_state   = ST_RUN;
                    end else begin
                        next_clr_cnt = clr_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        next_state = ST_CLEAR;
                    end
                end
                default: next_state = ST_RUN;
            endcase
        end
    end

    // The clear engine and host writes share the single write port; they
    // never collide because host commands are refused during CLEAR.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = address[IDX_WIDTH-1:0];
        mem_wbe   = byteenable;
        mem_wdata = writedata;
        if (rst_n_int && !stall) begin
            if (state == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt[IDX_WIDTH-1:0];
                mem_wbe   = '1;
                mem_wdata = '0;
            end else if (wr_acc && in_range) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (mem_wbe[i]) begin
                    mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // A write in the previous cycle has already landed in the array, so
    // the array lookup here naturally gives write-first behaviour.
    assign rd_word = in_range ? mem[address[IDX_WIDTH-1:0]] : '0;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            stg_valid     <= 1'b0;
            stg_data      <= '0;
            readdatavalid <= 1'b0;
            readdata      <= '0;
        end else if (!stall) begin
            if (READ_LATENCY == 1) begin
                readdatavalid <= rd_acc;
                if (rd_acc) begin
                    readdata <= rd_word;
                end
            end else begin
                stg_valid <= rd_acc;
                if (rd_acc) begin
                    stg_data <= rd_word;
                end
                readdatavalid <= stg_valid;
                if (stg_valid) begin
                    readdata <= stg_data;
                end
            end
        end
    end

endmodule
